// File: rtl/crack_dispatch.sv
// Splits the candidate space 0..MAX_PASS-1 across NUM_ENG engines and collects the first match.
// Define CRACK_DISPATCH_TIMER_EN to enable the elapsed-millisecond BCD counter.
module crack_dispatch #(
   parameter int unsigned     NUM_ENG      = 2,
   parameter int unsigned     PASS_W       = 32,
   parameter longint unsigned MAX_PASS     = 64'd2576980378,
   parameter int unsigned     TICKS_PER_MS = 100000,
   parameter int unsigned     BCD_DIGITS   = 7
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   output logic                      eng_start,
   output logic                      eng_abort,
   output logic [NUM_ENG*PASS_W-1:0] eng_low,
   output logic [NUM_ENG*PASS_W-1:0] eng_high,
   input  logic [NUM_ENG-1:0]        eng_done,
   input  logic [NUM_ENG-1:0]        eng_found,
   input  logic [NUM_ENG*PASS_W-1:0] eng_pass,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [PASS_W-1:0]         pass,
   output logic [$clog2(NUM_ENG):0]  found_idx,
   output logic [4*BCD_DIGITS-1:0]   elapsed_bcd
);

   localparam int unsigned     IDX_W = $clog2(NUM_ENG) + 1;
   localparam longint unsigned SPLIT = (MAX_PASS + 64'(NUM_ENG) - 64'd1) / 64'(NUM_ENG);
   localparam longint unsigned LAST  = MAX_PASS - 64'd1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]                state_q;
   logic [NUM_ENG*PASS_W-1:0] range_low, range_high;
   logic [PASS_W-1:0]         sel_pass;
   logic [IDX_W-1:0]          sel_idx;
   logic                      any_found, all_done;

   // Engines past the end of the space get a degenerate range at the last candidate
   for (genvar i = 0; i < NUM_ENG; i++) begin : g_range
      localparam longint unsigned LO     = SPLIT * 64'(i);
      localparam longint unsigned HI_RAW = SPLIT * 64'(i + 1) - 64'd1;
      localparam longint unsigned HI     = (HI_RAW > LAST) ? LAST : HI_RAW;
      assign range_low[i*PASS_W +: PASS_W]  = PASS_W'((LO > LAST) ? LAST : LO);
      assign range_high[i*PASS_W +: PASS_W] = PASS_W'(HI);
   end

   // Status is ignored during the launch cycle, while engines are still clearing
   assign any_found = !eng_start && (|eng_found);
   assign all_done  = !eng_start && (&eng_done);

   always_comb begin
      sel_pass = '0;
      sel_idx  = '0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         if (eng_found[i]) begin
            sel_pass = eng_pass[i*PASS_W +: PASS_W];
            sel_idx  = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         eng_low   <= '0;
         eng_high  <= '0;
         done      <= 1'b0;
         found     <= 1'b0;
         pass      <= '0;
         found_idx <= '0;
      end else begin
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) state_q <= LOAD;
            end
            LOAD: begin
               eng_low   <= range_low;
               eng_high  <= range_high;
               done      <= 1'b0;
               found     <= 1'b0;
               pass      <= '0;
               found_idx <= '0;
               eng_start <= 1'b1;
               state_q   <= RUN;
            end
            RUN: begin
               if (any_found) begin
                  pass      <= sel_pass;
                  found_idx <= sel_idx;
                  found     <= 1'b1;
                  done      <= 1'b1;
                  eng_abort <= 1'b1;
                  state_q   <= DONE;
               end else if (all_done) begin
                  done    <= 1'b1;
                  state_q <= DONE;
               end else if (abort) begin
                  eng_abort <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = (state_q == LOAD) || (state_q == RUN);

`ifdef CRACK_DISPATCH_TIMER_EN
   localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

   logic [PRE_W-1:0]        presc_q;
   logic [4*BCD_DIGITS-1:0] bcd_q, bcd_inc;
   logic                    all_nines, carry;

   always_comb begin
      bcd_inc   = bcd_q;
      carry     = 1'b1;
      all_nines = 1'b1;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] != 4'd9) all_nines = 1'b0;
         if (carry) begin
            if (bcd_q[4*d +: 4] == 4'd9) begin
               bcd_inc[4*d +: 4] = 4'd0;
            end else begin
               bcd_inc[4*d +: 4] = bcd_q[4*d +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || state_q == LOAD) begin
         presc_q <= '0;
         bcd_q   <= '0;
      end else if (state_q == RUN) begin
         if (presc_q == PRE_W'(TICKS_PER_MS - 1)) begin
            presc_q <= '0;
            if (!all_nines) bcd_q <= bcd_inc;
         end else begin
            presc_q <= presc_q + PRE_W'(1);
         end
      end
   end

   assign elapsed_bcd = bcd_q;
`else
   assign elapsed_bcd = '0;
`endif

endmodule

// File: tb/tb_crack_dispatch.sv
// Randomized bench for crack_dispatch: per-search outcomes predicted from scenario event times.
module tb_crack_dispatch;

   localparam int unsigned     NE    = 3;
   localparam int unsigned     PW    = 8;
   localparam longint unsigned MP    = 100;
   localparam int unsigned     TICKS = 10;
   localparam int unsigned     DIG   = 3;
   localparam int              NEVER = 100000;

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, start2 = 1'b0;
   logic eng_start, eng_abort, busy, done, found;
   logic [NE*PW-1:0] eng_low, eng_high, eng_pass = '0;
   logic [NE-1:0]    eng_done = '0, eng_found = '0;
   logic [PW-1:0]    pass;
   logic [$clog2(NE):0] found_idx;
   logic [4*DIG-1:0] elapsed_bcd;

   logic e2_start, e2_abort, e2_busy, e2_done, e2_found;
   logic [2*PW-1:0] e2_low, e2_high;
   logic [PW-1:0]   e2_pass;
   logic [1:0]      e2_idx;
   logic [4*DIG-1:0] e2_bcd;

   int n_checks = 0, n_fail = 0;
   int found_at[NE], done_at[NE], abort_at, start_at;
   logic [PW-1:0] pv[NE];

   crack_dispatch #(.NUM_ENG(NE), .PASS_W(PW), .MAX_PASS(MP), .TICKS_PER_MS(TICKS),
                    .BCD_DIGITS(DIG)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .eng_start(eng_start),
      .eng_abort(eng_abort), .eng_low(eng_low), .eng_high(eng_high), .eng_done(eng_done),
      .eng_found(eng_found), .eng_pass(eng_pass), .busy(busy), .done(done), .found(found),
      .pass(pass), .found_idx(found_idx), .elapsed_bcd(elapsed_bcd));

   crack_dispatch #(.NUM_ENG(2), .PASS_W(PW), .MAX_PASS(MP), .TICKS_PER_MS(TICKS),
                    .BCD_DIGITS(DIG)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0), .eng_start(e2_start),
      .eng_abort(e2_abort), .eng_low(e2_low), .eng_high(e2_high), .eng_done(2'b00),
      .eng_found(2'b00), .eng_pass({(2*PW){1'b0}}), .busy(e2_busy), .done(e2_done),
      .found(e2_found), .pass(e2_pass), .found_idx(e2_idx), .elapsed_bcd(e2_bcd));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint unsigned exp_low(input int n, input int i);
      longint unsigned split = (MP + longint'(n) - 1) / longint'(n);
      longint unsigned lo = split * longint'(i);
      return (lo > MP - 1) ? MP - 1 : lo;
   endfunction

   function automatic longint unsigned exp_high(input int n, input int i);
      longint unsigned split = (MP + longint'(n) - 1) / longint'(n);
      longint unsigned hi = split * longint'(i + 1) - 1;
      return (hi > MP - 1) ? MP - 1 : hi;
   endfunction

   function automatic logic [63:0] exp_bcd(input int run_cycles);
      logic [63:0] r = '0;
`ifdef CRACK_DISPATCH_TIMER_EN
      int ms = run_cycles / int'(TICKS);
      if (ms > 10 ** DIG - 1) ms = 10 ** DIG - 1;
      for (int d = 0; d < int'(DIG); d++) begin
         r[4*d +: 4] = 4'(ms % 10);
         ms = ms / 10;
      end
`else
      r = '0 + 0 * run_cycles;
`endif
      return r;
   endfunction

   task automatic clear_scenario();
      for (int i = 0; i < int'(NE); i++) begin
         found_at[i] = NEVER;
         done_at[i]  = NEVER;
         pv[i]       = PW'(exp_low(NE, i));
      end
      abort_at = NEVER;
      start_at = NEVER;
   endtask

   // outcome: 0 = match, 1 = exhausted, 2 = aborted
   task automatic run_search(input string tag);
      int k_end, outcome, idx;
      logic [PW-1:0] xp;
      logic [63:0] hold_pass, hold_bcd;
      bit anyf, alld;
      k_end = -1; outcome = 2; idx = 0; xp = '0;
      for (int k = 1; k < 400 && k_end < 0; k++) begin
         anyf = 0; alld = 1;
         for (int i = int'(NE) - 1; i >= 0; i--) begin
            if (found_at[i] <= k) begin anyf = 1; idx = i; xp = pv[i]; end
            if (done_at[i] > k) alld = 0;
         end
         if (anyf) begin outcome = 0; k_end = k; end
         else if (alld) begin outcome = 1; k_end = k; end
         else if (abort_at == k) begin outcome = 2; k_end = k; end
      end
      if (k_end < 0) begin
         check({tag, ".scenario_terminates"}, 0, 1);
         return;
      end
      start = 1'b1;
      step();
      check({tag, ".load_busy"}, busy, 1);
      check({tag, ".load_no_eng_start"}, eng_start, 0);
      start = 1'($urandom_range(0, 1));
      step();
      start = 1'b0;
      check({tag, ".run_eng_start"}, eng_start, 1);
      check({tag, ".run_done_clear"}, {done, found}, 0);
      for (int i = 0; i < int'(NE); i++) begin
         check($sformatf("%s.low%0d", tag, i), eng_low[i*PW +: PW], exp_low(NE, i));
         check($sformatf("%s.high%0d", tag, i), eng_high[i*PW +: PW], exp_high(NE, i));
      end
      for (int k = 0; k <= k_end; k++) begin
         for (int i = 0; i < int'(NE); i++) begin
            eng_found[i] = (found_at[i] <= k);
            eng_done[i]  = (done_at[i] <= k);
            eng_pass[i*PW +: PW] = pv[i];
         end
         abort = (k == abort_at);
         start = (k == start_at);
         step();
         abort = 1'b0;
         start = 1'b0;
         if (k < k_end) check($sformatf("%s.running_k%0d", tag, k), {busy, done, eng_start}, 3'b100);
      end
      check({tag, ".done"}, done, (outcome != 2));
      check({tag, ".found"}, found, (outcome == 0));
      check({tag, ".pass"}, pass, (outcome == 0) ? xp : 0);
      check({tag, ".found_idx"}, found_idx, (outcome == 0) ? idx : 0);
      check({tag, ".eng_abort"}, eng_abort, (outcome != 1));
      check({tag, ".busy_end"}, busy, 0);
      check({tag, ".elapsed"}, elapsed_bcd, exp_bcd(k_end + 1));
      hold_pass = 64'(pass);
      hold_bcd  = 64'(elapsed_bcd);
      eng_found = '0;
      eng_done  = '0;
      step();
      step();
      check({tag, ".abort_single"}, eng_abort, 0);
      check({tag, ".hold"}, {done, found, 64'(pass), 64'(elapsed_bcd)},
            {1'(outcome != 2), 1'(outcome == 0), hold_pass, hold_bcd});
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) step();
      check("reset.ctrl", {busy, done, found, eng_start, eng_abort}, 0);
      check("reset.data", {64'(pass), 64'(found_idx), 64'(elapsed_bcd)}, 0);
      reset_n = 1'b1;
      step();
      check("idle.busy", busy, 0);

      start2 = 1'b1;
      step();
      start2 = 1'b0;
      step();
      check("two_eng.low", e2_low, {8'd50, 8'd0});
      check("two_eng.high", e2_high, {8'd99, 8'd49});

      clear_scenario();
      found_at[0] = 3; found_at[1] = 3; pv[0] = 8'd7; pv[1] = 8'd63;
      run_search("dual_found");
      check("dual_found.pass_const", {64'(pass), 64'(found_idx)}, {64'd7, 64'd0});

      clear_scenario();
      done_at[0] = 2; done_at[1] = 5; done_at[2] = 4;
      run_search("all_done");
      clear_scenario();
      found_at[1] = 2; pv[1] = 8'd40;
      run_search("restart_from_done");

      clear_scenario();
      abort_at = 4;
      run_search("abort5");
      clear_scenario();
      abort_at = 6; found_at[1] = 6; pv[1] = 8'd50;
      run_search("abort_vs_found");
      clear_scenario();
      found_at[2] = 5; done_at[0] = 5; done_at[1] = 5; done_at[2] = 5; pv[2] = 8'd99;
      run_search("found_vs_done");

      clear_scenario();
      found_at[2] = 124; pv[2] = 8'd80;
      run_search("timer125");
`ifdef CRACK_DISPATCH_TIMER_EN
      check("timer125.const", elapsed_bcd, 12'h012);
`else
      check("timer125.const", elapsed_bcd, 12'h000);
`endif

      for (int s = 0; s < 20; s++) begin
         clear_scenario();
         for (int i = 0; i < int'(NE); i++) begin
            if ($urandom_range(0, 2) == 0) found_at[i] = int'($urandom_range(1, 30));
            done_at[i] = int'($urandom_range(1, 40));
            pv[i] = PW'(exp_low(NE, i) + longint'($urandom_range(0, 32'(exp_high(NE, i) - exp_low(NE, i)))));
         end
         if ($urandom_range(0, 2) == 0) abort_at = int'($urandom_range(1, 35));
         start_at = int'($urandom_range(1, 10));
         run_search($sformatf("rand%0d", s));
      end

      clear_scenario();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      reset_n = 1'b0;
      step();
      check("mid_reset.ctrl", {busy, done, found, eng_start, eng_abort}, 0);
      check("mid_reset.bcd", elapsed_bcd, 0);
      reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/crack_dispatch.md
CRACK_DISPATCH -- requirements
Module: crack_dispatch

Interface
REQ-001 SHALL have parameter NUM_ENG, default 2: number of brute-force engines, range 1..16.
REQ-002 SHALL have parameter PASS_W, default 32: candidate width in bits.
REQ-003 SHALL have parameter MAX_PASS, default 2576980378: number of candidates, searched as 0..MAX_PASS-1, and MAX_PASS <= 2^PASS_W.
REQ-004 SHALL have parameter TICKS_PER_MS, default 100000: clk cycles per millisecond.
REQ-005 SHALL have parameter BCD_DIGITS, default 7: digit count of the elapsed-time counter.
REQ-006 clk  in  1  clock; all logic is on the rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  single-cycle request to begin a search.
REQ-009 abort  in  1  single-cycle request to cancel a running search.
REQ-010 eng_start  out  1  single-cycle pulse that launches all engines.
REQ-011 eng_abort  out  1  single-cycle pulse that cancels all engines.
REQ-012 eng_low, eng_high  out  NUM_ENG*PASS_W each  inclusive per-engine range, packed with engine i in slice [i*PASS_W +: PASS_W].
REQ-013 eng_done, eng_found  in  NUM_ENG each  per-engine status, level, held until the next eng_start.
REQ-014 eng_pass  in  NUM_ENG*PASS_W  per-engine matched candidate, valid while eng_found[i] is high.
REQ-015 busy, done, found  out  1 each  search active / result valid / match exists.
REQ-016 pass  out  PASS_W  matched candidate.
REQ-017 found_idx  out  $clog2(NUM_ENG)+1  index of the winning engine.
REQ-018 elapsed_bcd  out  4*BCD_DIGITS  elapsed search time in milliseconds, BCD, least-significant digit in [3:0].

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-020 IDLE->LOAD on start; DONE->LOAD on start; start in LOAD or RUN SHALL be ignored.
REQ-021 LOAD SHALL last exactly one cycle: register ranges, clear timer and results, then go to RUN.
REQ-022 Ranges: SPLIT = ceil(MAX_PASS/NUM_ENG); low_i = SPLIT*i; high_i = min(SPLIT*(i+1)-1, MAX_PASS-1), computed at elaboration.
REQ-023 An engine with low_i > MAX_PASS-1 SHALL have eng_low = eng_high = MAX_PASS-1, and its status SHALL still be honoured.
REQ-024 eng_start SHALL pulse in the first RUN cycle only.
REQ-025 busy SHALL be high exactly in LOAD and RUN.
REQ-026 RUN, any eng_found high: capture pass and found_idx of the lowest-index asserting engine, set found=1 and done=1, go to DONE, pulse eng_abort next cycle.
REQ-027 RUN, all eng_done high with no eng_found high: set found=0 and done=1, go to DONE.
REQ-028 Status inputs SHALL be ignored in the eng_start cycle.
REQ-029 RUN with abort and no eng_found: go to IDLE, pulse eng_abort, keep done=0.
REQ-030 If found and all-done occur in the same cycle, found SHALL win.
REQ-031 If found and abort occur in the same cycle, found SHALL win and abort SHALL be dropped.
REQ-032 DONE SHALL hold done, found, pass, found_idx and elapsed_bcd stable until the next LOAD.
REQ-033 Latency from eng_found rising to done rising SHALL be 1 cycle.

Reset
REQ-034 With reset_n low at a clock edge, the FSM SHALL go to IDLE.
REQ-035 Under reset, busy, done, found, eng_start, eng_abort SHALL be 0; pass, found_idx and elapsed_bcd SHALL be 0.
REQ-036 Reset mid-RUN SHALL NOT pulse eng_abort; the engines share reset_n.

Configuration
REQ-037 Macro CRACK_DISPATCH_TIMER_EN defined: elapsed_bcd SHALL count ms in RUN only.
REQ-038 Timer behaviour: prescaler of TICKS_PER_MS cycles, per-digit BCD carry chain, saturates at all nines, cleared in LOAD, frozen in DONE and IDLE.
REQ-039 Macro CRACK_DISPATCH_TIMER_EN undefined: no prescaler or counter logic; elapsed_bcd SHALL be constant 0.

Verification
REQ-040 NUM_ENG=2, MAX_PASS=100 -> eng_low=0/50, eng_high=49/99.
REQ-041 NUM_ENG=3, MAX_PASS=100 -> eng_low=0/34/68, eng_high=33/67/99 (clamped).
REQ-042 Engines 0 and 1 assert eng_found in the same cycle with pass 7 and 63 -> next cycle done=1, found=1, pass=7, found_idx=0; eng_abort pulses once.
REQ-043 All eng_done high, no eng_found -> done=1, found=0; then start -> LOAD clears done, eng_start re-pulses.
REQ-044 abort on the 5th RUN cycle -> IDLE, eng_abort=1 for 1 cycle, done=0; abort together with eng_found[1] -> found=1.
REQ-045 TIMER_EN defined, TICKS_PER_MS=10, found after 125 RUN cycles -> elapsed_bcd=0x12; TIMER_EN undefined -> 0.
